// File: rtl/sample_pkg.sv
// Shared widths and FSM state type for the sample capture controller.
package sample_pkg;
   localparam int SAMPLE_W         = 8;
   localparam int SAMPLES_PER_WORD = 8;
   localparam int WORD_W           = 64;
   localparam int IDX_W            = $clog2(SAMPLES_PER_WORD);

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;
endpackage

// File: rtl/sample_capture_ctrl_strobe_gen.sv
// Clock-enable divider: one-cycle strobe every DIV_COUNT+1 fastclk cycles while run is high.
module strobe_gen #(
   parameter int DIV_COUNT = 3333,
   parameter int DIV_W     = 12
) (
   input  logic fastclk,
   input  logic reset,
   input  logic run,
   output logic strobe
);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT);

   logic [DIV_W-1:0] count_reg;

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (!run || count_reg == DIV_LAST) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign strobe = run && (count_reg == DIV_LAST);
endmodule

// File: rtl/sample_capture_ctrl.sv
// Packs 8 strobed samples of an 8-bit input into a 64-bit word with a valid/ready output.
// Optional macro SAMPLE_CAPTURE_CTRL_OVF_COUNT_EN adds a saturating overrun_count output.
module sample_capture_ctrl
   import sample_pkg::*;
#(
   parameter int DIV_COUNT = 3333,
   parameter int DIV_W     = 12
) (
   input  logic                fastclk,
   input  logic                reset,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] bits_in,
   output logic [WORD_W-1:0]   word_out,
   output logic                word_valid,
   input  logic                word_ready,
   output logic                sample_strobe,
   output logic                busy,
   output logic                overrun
`ifdef SAMPLE_CAPTURE_CTRL_OVF_COUNT_EN
   ,
   output logic [7:0]          overrun_count
`endif
);
   state_t state_reg;
   state_t state_next;

   logic [IDX_W-1:0]    idx_reg;
   logic [SAMPLE_W-1:0] fill_buf [SAMPLES_PER_WORD];
   logic [WORD_W-1:0]   full_word;
   logic                run;
   logic                abort;
   logic                word_complete;

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (enable)  state_next = FILL;
         FILL:    if (!enable) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg == FILL);
   end

   // Dropping enable clears the divider on the same edge that leaves FILL,
   // so the counter already reads 0 in the first IDLE cycle.
   assign run   = busy && enable;
   assign abort = busy && !enable;

   strobe_gen #(
      .DIV_COUNT (DIV_COUNT),
      .DIV_W     (DIV_W)
   ) u_strobe_gen (
      .fastclk (fastclk),
      .reset   (reset),
      .run     (run),
      .strobe  (sample_strobe)
   );

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         idx_reg <= '0;
         for (int i = 0; i < SAMPLES_PER_WORD; i++) fill_buf[i] <= '0;
      end else if (abort) begin
         idx_reg <= '0;
         for (int i = 0; i < SAMPLES_PER_WORD; i++) fill_buf[i] <= '0;
      end else if (sample_strobe) begin
         fill_buf[idx_reg] <= bits_in;
         idx_reg           <= idx_reg + 1'b1;
      end
   end

   assign word_complete = sample_strobe && (idx_reg == IDX_W'(SAMPLES_PER_WORD - 1));

   // The top lane comes straight from bits_in: it is being captured on this very edge.
   always_comb begin
      full_word = '0;
      for (int i = 0; i < SAMPLES_PER_WORD - 1; i++) begin
         full_word[i*SAMPLE_W +: SAMPLE_W] = fill_buf[i];
      end
      full_word[WORD_W-1 -: SAMPLE_W] = bits_in;
   end

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         word_out   <= '0;
         word_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (word_complete && (!word_valid || word_ready)) begin
         word_out   <= full_word;
         word_valid <= 1'b1;
      end else if (word_complete) begin
         overrun    <= 1'b1;
      end else if (word_valid && word_ready) begin
         word_valid <= 1'b0;
      end
   end

`ifdef SAMPLE_CAPTURE_CTRL_OVF_COUNT_EN
   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         overrun_count <= '0;
      end else if (word_complete && word_valid && !word_ready && overrun_count != 8'hFF) begin
         overrun_count <= overrun_count + 1'b1;
      end
   end
`endif
endmodule

// File: doc/sample_capture_ctrl.md
SAMPLE_CAPTURE_CTRL -- requirements
Module: sample_capture_ctrl

Interface
REQ-001 Parameter DIV_COUNT, default 3333, strobe period minus one in fastclk cycles; 50 MHz / 3334 ≈ 15 kHz.
REQ-002 Parameter DIV_W, default 12, divider counter width; SHALL satisfy DIV_COUNT < 2**DIV_W.
REQ-003 fastclk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  level; 1 = run capture, 0 = stop and abort the partial word.
REQ-006 bits_in  in  8  parallel 1-bit sample inputs; bit k = input channel k.
REQ-007 word_out  out  64  assembled word of 8 samples.
REQ-008 word_valid  out  1  word_out holds an unconsumed word.
REQ-009 word_ready  in  1  consumer accepts word_out when word_valid && word_ready.
REQ-010 sample_strobe  out  1  one-fastclk-cycle pulse marking each sample instant.
REQ-011 busy  out  1  high in FILL state.
REQ-012 overrun  out  1  sticky flag: a completed word was dropped; cleared only by reset.

Function
REQ-013 No derived clock SHALL be generated; sampling SHALL use sample_strobe as a clock enable on fastclk.
REQ-014 FSM states: IDLE, FILL. IDLE->FILL when enable=1; FILL->IDLE when enable=0.
REQ-015 Divider counter SHALL be held at 0 in IDLE and count 0..DIV_COUNT in FILL, wrapping to 0.
REQ-016 sample_strobe SHALL be 1 exactly in cycles where state=FILL and counter=DIV_COUNT.
REQ-017 First strobe SHALL occur DIV_COUNT+1 cycles after the first FILL cycle; subsequent strobes every DIV_COUNT+1 cycles.
REQ-018 On each strobe, bits_in SHALL be registered into byte lane idx of the fill buffer, bits [8*idx+7:8*idx]; idx then increments, 3 bits, wrapping 7->0.
REQ-019 The strobe with idx=7 completes a word; the full 64-bit buffer, including the lane-7 byte captured that cycle, SHALL be offered to the output register on the next edge.
REQ-020 Output register loads and word_valid rises when the word completes and (word_valid=0 or word_ready=1); 1 cycle latency from the final strobe.
REQ-021 word_out SHALL stay stable while word_valid=1 and word_ready=0.
REQ-022 Acceptance with no completion in the same cycle SHALL clear word_valid; word_out retains its value.
REQ-023 Completion and acceptance in the same cycle SHALL load the new word, keep word_valid=1, and not set overrun.
REQ-024 Completion while word_valid=1 and word_ready=0 SHALL drop the new word, keep the old one, and set overrun.
REQ-025 enable=0 during FILL SHALL discard the partial buffer, reset idx to 0 and counter to 0, and leave any pending output word and word_valid unaffected.
REQ-026 The capture side SHALL never stall on word_ready; capture continues across words while enable=1.
REQ-027 busy SHALL equal (state=FILL).

Reset
REQ-028 On reset=1, asynchronously: state=IDLE, counter=0, idx=0, fill buffer=0, word_out=0, word_valid=0, sample_strobe=0, overrun=0.
REQ-029 Reset asserted mid-word SHALL discard all partial and pending data; no word is emitted after release until 8 new strobes occur.

Configuration
REQ-030 Macro SAMPLE_CAPTURE_CTRL_OVF_COUNT_EN.
REQ-031 Defined: extra output overrun_count, out, 8, saturating count of dropped words; reset to 0; holds at 255.
REQ-032 Undefined: port overrun_count SHALL be absent; all other behaviour identical.

Structure
REQ-033 Shared package sample_pkg SHALL hold SAMPLE_W=8, SAMPLES_PER_WORD=8, WORD_W=64, and the FSM state enum type.
REQ-034 The divider SHALL be a sub-module strobe_gen (ports fastclk, reset, run, strobe; parameters DIV_COUNT, DIV_W).

Verification (bench uses DIV_COUNT=3)
REQ-035 Basic: enable=1, bits_in = 0x11, 0x22, ... 0x88 on successive strobes, word_ready=1 -> word_out=0x8877665544332211, word_valid high for 1 cycle, strobe spacing 4 cycles.
REQ-036 Backpressure: word_ready=0 through two word completions -> first word held unchanged, overrun=1, overrun_count=1 if compiled in.
REQ-037 Simultaneous: word_ready pulsed in the exact completion cycle of word 2 -> word 2 loaded, word_valid stays 1, overrun=0.
REQ-038 Abort: enable dropped after 5 samples, re-raised -> next word contains only the 8 samples captured after re-enable.
REQ-039 Reset mid-word after 3 samples -> all outputs 0 immediately, without a clock edge; first word emitted only after 8 new strobes.
REQ-040 Saturation (macro defined): 300 dropped words -> overrun_count=255.
